// File: rtl/sample_coding_pkg.sv
// Symbol coding shared by the sample coder and sample_decoder.
// One data bit per 2-bit symbol; any symbol with the MSB set is illegal.
package sample_coding_pkg;

    localparam logic [1:0] SYM_ZERO = 2'b00;
    localparam logic [1:0] SYM_ONE  = 2'b01;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_ERR_W = 16;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    function automatic logic is_violation(input logic [1:0] s);
        return s[1];
    endfunction

    function automatic logic sym_bit(input logic [1:0] s);
        return s[0];
    endfunction

    function automatic logic [1:0] encode_bit(input logic b);
        return b ? SYM_ONE : SYM_ZERO;
    endfunction

endpackage

// File: rtl/sample_deser.sv
// LSB-first bit deserialiser: acc, bit counter and completion pulse.
// An illegal symbol discards the partial word and restarts at bit 0.
module sample_deser
    import sample_coding_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stb,
    input  logic [1:0]       sym,
    output logic             done,
    output logic [WIDTH-1:0] word
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             legal;
    logic             bad;
    logic             last;

    assign bad   = stb & is_violation(sym);
    assign legal = stb & ~is_violation(sym);
    assign last  = (cnt == CW'(WIDTH - 1));
    assign done  = legal & last;

    // The final bit bypasses acc so the word is ready in the strobe cycle.
    assign word = {sym_bit(sym), acc[WIDTH-2:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (bad) begin
            acc <= '0;
            cnt <= '0;
        end else if (legal) begin
            acc[cnt] <= sym_bit(sym);
            cnt      <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sample_decoder.sv
// Sample symbol decoder: deserialiser, one-entry output buffer, error flags.
// Define SAMPLE_DECODER_ERRCNT_EN to implement the err_count counter.
module sample_decoder
    import sample_coding_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ERR_W = DEF_ERR_W
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             sym_stb,
    input  logic [1:0]       sym,
    output logic [WIDTH-1:0] word_o,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             violation,
    output logic             overflow,
    input  logic             err_clr,
    output logic [ERR_W-1:0] err_count
);

    logic             done;
    logic [WIDTH-1:0] new_word;
    logic             viol_ev;
    logic             ovf_ev;
    logic             load;
    logic             drain;
    out_state_t       state;
    out_state_t       state_nxt;

    sample_deser #(
        .WIDTH (WIDTH)
    ) u_deser (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .stb  (sym_stb),
        .sym  (sym),
        .done (done),
        .word (new_word)
    );

    assign viol_ev    = sym_stb & is_violation(sym);
    assign word_valid = (state == OUT_FULL);
    assign drain      = word_valid & word_ready;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        ovf_ev    = 1'b0;
        unique case (state)
            OUT_EMPTY: begin
                if (done) begin
                    load      = 1'b1;
                    state_nxt = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (done && word_ready) begin
                    load = 1'b1;
                end else if (done) begin
                    ovf_ev = 1'b1;
                end else if (word_ready) begin
                    state_nxt = OUT_EMPTY;
                end
            end
            default: state_nxt = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state  <= OUT_EMPTY;
            word_o <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                word_o <= new_word;
            end
        end
    end

    // A new event in the err_clr cycle wins over the clear.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            violation <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (viol_ev) begin
                violation <= 1'b1;
            end else if (err_clr) begin
                violation <= 1'b0;
            end
            if (ovf_ev) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef SAMPLE_DECODER_ERRCNT_EN
    logic [ERR_W-1:0] err_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            err_q <= '0;
        end else if (viol_ev && err_clr) begin
            err_q <= ERR_W'(1);
        end else if (viol_ev) begin
            if (err_q != '1) begin
                err_q <= err_q + 1'b1;
            end
        end else if (err_clr) begin
            err_q <= '0;
        end
    end

    assign err_count = err_q;
`else
    assign err_count = '0;
`endif

    // drain is informational for readers of the FSM; keep it referenced.
    logic unused_drain;
    assign unused_drain = drain;

endmodule

// File: tb/tb_sample_decoder.sv
// Scoreboard bench for sample_decoder: directed plan cases plus random traffic.
// Expected words are queued by a bit-list model; a negedge monitor checks them.
module tb_sample_decoder;
    import sample_coding_pkg::*;

    localparam int WIDTH = 8;
    localparam int ERR_W = 16;

    logic             sys_clk = 1'b0;
    logic             sys_rst = 1'b1;
    logic             sym_stb = 1'b0;
    logic [1:0]       sym = 2'b00;
    logic [WIDTH-1:0] word_o;
    logic             word_valid;
    logic             word_ready = 1'b0;
    logic             violation;
    logic             overflow;
    logic             err_clr = 1'b0;
    logic [ERR_W-1:0] err_count;

    sample_decoder #(
        .WIDTH (WIDTH),
        .ERR_W (ERR_W)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .sym_stb    (sym_stb),
        .sym        (sym),
        .word_o     (word_o),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .violation  (violation),
        .overflow   (overflow),
        .err_clr    (err_clr),
        .err_count  (err_count)
    );

    always #5 sys_clk = ~sys_clk;

    int passed = 0;
    int total = 0;
    bit mon_en = 1'b0;

    // reference model state
    bit          bits[$];
    logic [31:0] expq[$];
    bit          m_full = 0;
    bit          m_viol = 0;
    bit          m_ovf = 0;
    int          m_cnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int cnt_exp(input int c);
`ifdef SAMPLE_DECODER_ERRCNT_EN
        return c;
`else
        return 0;
`endif
    endfunction

    // Called at posedge+2: applies inputs, advances the model, waits the edge.
    task automatic cyc(input bit stb, input logic [1:0] s, input bit rdy,
                       input bit clr, input bit rst);
        bit          n_full;
        bit          n_viol;
        bit          n_ovf;
        int          n_cnt;
        bit          vev;
        bit          complete;
        logic [31:0] w;
        sym_stb    = stb;
        sym        = s;
        word_ready = rdy;
        err_clr    = clr;
        sys_rst    = rst;
        n_full = m_full;
        n_viol = m_viol;
        n_ovf  = m_ovf;
        n_cnt  = m_cnt;
        if (rst) begin
            bits.delete();
            if (m_full) void'(expq.pop_back());
            n_full = 0;
            n_viol = 0;
            n_ovf  = 0;
            n_cnt  = 0;
        end else begin
            vev = 0;
            complete = 0;
            w = 0;
            if (stb && s[1]) begin
                vev = 1;
                bits.delete();
            end else if (stb) begin
                bits.push_back(s[0]);
                if (bits.size() == WIDTH) begin
                    for (int i = 0; i < WIDTH; i++) w[i] = bits[i];
                    bits.delete();
                    complete = 1;
                end
            end
            if (clr) begin
                n_viol = 0;
                n_ovf  = 0;
                n_cnt  = 0;
            end
            if (vev) begin
                n_viol = 1;
                n_cnt  = clr ? 1 : ((m_cnt == (1 << ERR_W) - 1) ? m_cnt : m_cnt + 1);
            end
            if (complete) begin
                if (!m_full || rdy) begin
                    expq.push_back(w);
                    n_full = 1;
                end else begin
                    n_ovf = 1;
                end
            end else if (m_full && rdy) begin
                n_full = 0;
            end
        end
        @(posedge sys_clk);
        #1;
        m_full = n_full;
        m_viol = n_viol;
        m_ovf  = n_ovf;
        m_cnt  = n_cnt;
        #1;
    endtask

    task automatic idle(input bit rdy);
        cyc(0, 2'b00, rdy, 0, 0);
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input bit rdy_rest,
                             input bit rdy_last);
        for (int i = 0; i < WIDTH; i++)
            cyc(1, encode_bit(w[i]), (i == WIDTH - 1) ? rdy_last : rdy_rest, 0, 0);
    endtask

    // monitor: compares outputs each cycle and pops on every handshake
    always @(negedge sys_clk) begin
        if (mon_en) begin
            chk("word_valid", word_valid, m_full);
            chk("violation", violation, m_viol);
            chk("overflow", overflow, m_ovf);
            chk("err_count", err_count, cnt_exp(m_cnt));
            if (word_valid && word_ready && !sys_rst) begin
                if (expq.size() == 0) begin
                    chk("unexpected_word", word_o, 32'hDEAD_BEEF);
                end else begin
                    chk("word_o", word_o, expq.pop_front() & ((1 << WIDTH) - 1));
                end
            end
        end
    end

    initial begin
        @(posedge sys_clk);
        #2;
        cyc(0, 2'b00, 0, 0, 1);
        cyc(0, 2'b00, 0, 0, 1);
        chk("rst_word_o", word_o, 0);
        chk("rst_valid", word_valid, 0);
        chk("rst_err_count", err_count, 0);
        mon_en = 1'b1;

        // serial completion
        send_word(8'hA5, 1, 1);
        chk("a5_word", word_o, 8'hA5);
        chk("a5_valid", word_valid, 1);
        idle(1);
        chk("a5_one_cycle", word_valid, 0);

        // mid-word violation
        cyc(1, SYM_ONE, 1, 0, 0);
        cyc(1, SYM_ZERO, 1, 0, 0);
        cyc(1, SYM_ONE, 1, 0, 0);
        cyc(1, 2'b10, 1, 0, 0);
        send_word(8'h3C, 1, 1);
        chk("viol_word", word_o, 8'h3C);
        chk("viol_flag", violation, 1);
        chk("viol_cnt", err_count, cnt_exp(1));
        idle(1);
        cyc(0, 2'b00, 1, 1, 0);

        // overrun
        send_word(8'h11, 0, 0);
        send_word(8'h22, 0, 0);
        chk("ovr_word", word_o, 8'h11);
        chk("ovr_flag", overflow, 1);
        idle(1);
        chk("ovr_drained", word_valid, 0);
        cyc(0, 2'b00, 0, 1, 0);

        // drain and complete in the same cycle
        send_word(8'h11, 0, 0);
        send_word(8'h22, 0, 1);
        chk("dc_word", word_o, 8'h22);
        chk("dc_valid", word_valid, 1);
        chk("dc_ovf", overflow, 0);
        idle(1);

        // err_clr together with an illegal symbol
        cyc(1, 2'b11, 1, 0, 0);
        cyc(1, 2'b10, 1, 1, 0);
        chk("clr_viol", violation, 1);
        chk("clr_cnt", err_count, cnt_exp(1));

        // reset mid-word
        for (int i = 0; i < 5; i++) cyc(1, SYM_ONE, 0, 0, 0);
        cyc(0, 2'b00, 0, 0, 1);
        chk("rstm_word", word_o, 0);
        chk("rstm_valid", word_valid, 0);
        chk("rstm_viol", violation, 0);
        chk("rstm_ovf", overflow, 0);
        send_word(8'hFF, 1, 1);
        chk("rstm_ff", word_o, 8'hFF);
        idle(1);

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            bit          stb;
            logic [1:0]  s;
            stb = ($urandom_range(0, 3) != 0);
            s   = ($urandom_range(0, 11) == 0) ? {1'b1, 1'($urandom)} :
                  encode_bit(1'($urandom));
            cyc(stb, s, 1'($urandom), ($urandom_range(0, 40) == 0),
                ($urandom_range(0, 300) == 0));
        end

        for (int i = 0; i < 4; i++) idle(1);
        chk("queue_empty", expq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sample_decoder.md
# sample_decoder

Receive-side counterpart of the sampling path's 1-bit-to-2-bit symbol coder. It consumes strobed 2-bit symbols, recovers one data bit per legal symbol, and deserialises the bits LSB-first into WIDTH-bit words. Words leave on a valid/ready handshake. The block sits between the sample transport and the monitor's capture buffer, and it flags code violations and output overruns.

## Interface
- WIDTH, 8: bits per output word; legal range 2..32.
- ERR_W, 16: width of the violation counter.
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  reset, synchronous and active-high.
- sym_stb  in  1  symbol strobe; sym is sampled when high.
- sym  in  2  coded symbol: 2'b00 means bit 0, 2'b01 means bit 1, 2'b1x is a code violation.
- word_o  out  WIDTH  assembled word; first received bit is in bit 0.
- word_valid  out  1  word_o holds an undelivered word.
- word_ready  in  1  consumer accepts word_o when word_valid and word_ready are both high.
- violation  out  1  sticky: at least one illegal symbol has been received.
- overflow  out  1  sticky: at least one completed word has been dropped.
- err_clr  in  1  clears violation, overflow and err_count.
- err_count  out  ERR_W  saturating count of illegal symbols.

## Operation
- Deserialiser state:
  - Shift register `acc[WIDTH-1:0]`.
  - Bit counter `cnt`, range 0..WIDTH-1.
  - Output register plus word_valid, forming a one-entry buffer.
- Legal symbol with sym_stb high:
  - Write acc[cnt] = sym[0] and increment cnt.
  - At cnt == WIDTH-1 the word is complete: cnt wraps to 0.
- Word completion:
  - Loads the output register if it is empty or is being drained this cycle (word_valid & word_ready).
  - Otherwise the new word is dropped, overflow is set, and the held word_o is left untouched.
- Illegal symbol (sym[1]=1) with sym_stb high:
  - Discard the partial word and set cnt to 0.
  - Set violation and increment err_count, saturating at all-ones.
  - A held output word is unaffected.
- Output register states:
  - EMPTY goes to FULL on word completion.
  - FULL goes to EMPTY on word_ready without a completion in the same cycle.
  - FULL with word_ready and a completion in the same cycle stays FULL holding the new word; overflow is not set.
- err_clr:
  - Clears the sticky flags and err_count.
  - If err_clr and a new event occur in the same cycle, the event wins: the flag is set, and err_count becomes 1 for a violation.
- sym is ignored while sym_stb is low.

## Timing
- Reset values:
  - word_o = 0, word_valid = 0, violation = 0, overflow = 0, err_count = 0.
  - Internally, cnt = 0 and acc = 0.
- Reset asserted mid-word discards the partial word and any held word.
- Latency: word_valid rises in the cycle after the sym_stb that carries the WIDTH-th bit.
- Throughput: one symbol per cycle. Back-to-back words are lossless if word_ready is high in the cycle each word completes.
- word_o is stable while word_valid is high and word_ready is low.
- Flags and err_count update one cycle after the causing strobe.

## Configuration
- Macro SAMPLE_DECODER_ERRCNT_EN.
- Defined: err_count is implemented as specified.
- Undefined:
  - No counter register exists and err_count is tied to 0.
  - The violation flag, the discard behaviour and all other functions are unchanged.

## Structure
- Shared package sample_coding_pkg holds:
  - SYM_ZERO = 2'b00 and SYM_ONE = 2'b01.
  - The violation test (sym[1] set).
  - The default WIDTH.
- The coder side uses the same package constants.
- One sub-module, sample_deser, contains acc, cnt and the completion pulse.
- The top level holds the output register, the handshake, the flags and the counter.

## Test plan
- Serial completion:
  - Stimulus: WIDTH=8, word_ready=1, bits 1,0,1,0,0,1,0,1 as symbols 01,00,01,00,00,01,00,01.
  - Response: word_o=8'hA5 and word_valid high for exactly one cycle, starting one cycle after the 8th strobe.
- Mid-word violation:
  - Stimulus: 3 legal symbols, then sym=2'b10, then 8 symbols for 0x3C.
  - Response: output 0x3C only; violation=1; err_count=1.
- Overrun:
  - Stimulus: word_ready=0, send 0x11 then 0x22.
  - Response: word_o stays 0x11; overflow=1.
  - Follow-up: raise word_ready for one cycle. Response: word_valid goes 0.
- Drain and complete in the same cycle:
  - Stimulus: word 0x11 held; 0x22 completes in the cycle word_ready=1.
  - Response: word_o=0x22, word_valid stays 1, overflow=0.
- err_clr:
  - Stimulus: err_clr pulsed in the same cycle as an illegal symbol.
  - Response: err_count=1, violation=1.
  - Without the macro, err_count stays 0.
- Reset mid-word:
  - Stimulus: sys_rst pulsed after 5 bits, then 8 bits of 0xFF.
  - Response: all outputs 0 after reset; the next word is 0xFF.
